// File: rtl/pwm_multi_channel_if.sv
// Byte-wide register bus shared by the SPI front-ends and the multi-channel PWM block.
// The master drives the address, write strobe and data; the slave returns combinational read data.
interface pwm_multi_channel_if;
    logic [7:0] addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] rd_data;

    modport master (output addr, output wr_en, output wr_data, input rd_data);
    modport slave  (input addr, input wr_en, input wr_data, output rd_data);
endinterface

// File: rtl/pwm_multi_channel.sv
// NUM_CH independent PWM channels (edge/centre aligned, double-buffered period/duty) behind a byte bus.
// Define PWM_IRQ_EN to add the sticky STATUS (0x02), IRQ_MASK (0x03) registers and the irq output.
module pwm_multi_channel #(
    parameter int         NUM_CH = 4,
    parameter int         CNT_W  = 32,
    parameter logic [7:0] ID_VAL = 8'h97
) (
    input  logic                clk,
    input  logic                rst_n,
    pwm_multi_channel_if.slave  bus,
    output logic [NUM_CH-1:0]   pwm,
    output logic [NUM_CH-1:0]   period_end
`ifdef PWM_IRQ_EN
    ,
    output logic                irq
`endif
);
    localparam logic [31:0]      PER_RST   = 32'h0001_86A0;
    localparam logic [31:0]      DUTY_RST  = 32'h0000_C350;
    localparam logic [CNT_W-1:0] PER_RST_W = PER_RST[CNT_W-1:0];
    localparam logic [CNT_W-1:0] DUTY_RST_W = DUTY_RST[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [7:0] lane_rd(input logic [CNT_W-1:0] val, input logic [1:0] lane);
        return 8'(32'(val) >> {lane, 3'b000});
    endfunction

    // Lanes beyond CNT_W are dropped by the final truncation.
    function automatic logic [CNT_W-1:0] lane_wr(input logic [CNT_W-1:0] val, input logic [1:0] lane,
                                                 input logic [7:0] data);
        logic [31:0] ext;
        ext = 32'(val);
        ext[{lane, 3'b000} +: 8] = data;
        return ext[CNT_W-1:0];
    endfunction

    logic       global_en_r;
    logic       restart_s;
    logic [7:0] ch_rd_s [NUM_CH];
    logic [7:0] rd_s;

    assign restart_s = bus.wr_en && (bus.addr == 8'h01) && bus.wr_data[1];

    // global enable; sync_restart is a pulse and is never stored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            global_en_r <= 1'b0;
        end else if (bus.wr_en && (bus.addr == 8'h01)) begin
            global_en_r <= bus.wr_data[0];
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        localparam logic [3:0] CH_PAGE = 4'(n + 1);

        logic [2:0]       ctrl_r;
        logic [CNT_W-1:0] per_sh_r, duty_sh_r, per_act_r, duty_act_r, cnt_r, last_s;
        logic             dir_down_r, center_act_r, pwm_r;
        logic             wr_s, run_s, pe_s, act_s;
        logic [1:0]       lane_s;
        logic [7:0]       rd_val_s;

        assign wr_s   = bus.wr_en && (bus.addr[7:4] == CH_PAGE);
        assign run_s  = global_en_r && ctrl_r[0];
        assign last_s = per_act_r - CNT_ONE;
        // offsets 1..4 and 5..8 share the same low-bit lane mapping
        assign lane_s = 2'(bus.addr[1:0] - 2'd1);
        assign act_s  = run_s && (per_act_r != CNT_ZERO) && (cnt_r < duty_act_r);

        // period_end decodes the last cycle of the current period
        always_comb begin
            pe_s = 1'b0;
            if (run_s && (per_act_r != CNT_ZERO)) begin
                pe_s = center_act_r ? (dir_down_r && (cnt_r == CNT_ZERO)) : (cnt_r == last_s);
            end else begin
                pe_s = 1'b0;
            end
        end

        // bus writes into control and shadow registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctrl_r    <= 3'b000;
                per_sh_r  <= PER_RST_W;
                duty_sh_r <= DUTY_RST_W;
            end else if (wr_s) begin
                case (bus.addr[3:0])
                    4'h0:                   ctrl_r    <= bus.wr_data[2:0];
                    4'h1, 4'h2, 4'h3, 4'h4: per_sh_r  <= lane_wr(per_sh_r, lane_s, bus.wr_data);
                    4'h5, 4'h6, 4'h7, 4'h8: duty_sh_r <= lane_wr(duty_sh_r, lane_s, bus.wr_data);
                    default:                ctrl_r    <= ctrl_r;
                endcase
            end
        end

        // counter, direction, active period/duty/mode and the registered output level
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_r        <= CNT_ZERO;
                dir_down_r   <= 1'b0;
                per_act_r    <= PER_RST_W;
                duty_act_r   <= DUTY_RST_W;
                center_act_r <= 1'b0;
                pwm_r        <= 1'b0;
            end else begin
                pwm_r <= act_s ? ~ctrl_r[1] : ctrl_r[1];
                if (restart_s || !run_s || pe_s) begin
                    cnt_r        <= CNT_ZERO;
                    dir_down_r   <= 1'b0;
                    per_act_r    <= per_sh_r;
                    duty_act_r   <= duty_sh_r;
                    center_act_r <= ctrl_r[2];
                end else if (per_act_r == CNT_ZERO) begin
                    cnt_r      <= CNT_ZERO;
                    dir_down_r <= 1'b0;
                end else if (!center_act_r) begin
                    cnt_r <= cnt_r + CNT_ONE;
                end else if (dir_down_r) begin
                    cnt_r <= cnt_r - CNT_ONE;
                end else if (cnt_r == last_s) begin
                    // the top count is held for a second cycle while turning down
                    dir_down_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end
        end

        // per-channel read value; the page match is applied in the top-level mux
        always_comb begin
            case (bus.addr[3:0])
                4'h0:                   rd_val_s = {5'b00000, ctrl_r};
                4'h1, 4'h2, 4'h3, 4'h4: rd_val_s = lane_rd(per_sh_r, lane_s);
                4'h5, 4'h6, 4'h7, 4'h8: rd_val_s = lane_rd(duty_sh_r, lane_s);
                default:                rd_val_s = 8'h00;
            endcase
        end

        assign ch_rd_s[n]    = rd_val_s;
        assign pwm[n]        = pwm_r;
        assign period_end[n] = pe_s;
    end

`ifdef PWM_IRQ_EN
    logic [NUM_CH-1:0] status_r, mask_r, clr_s;
    logic              irq_r;

    assign clr_s = (bus.wr_en && (bus.addr == 8'h02)) ? NUM_CH'(bus.wr_data) : {NUM_CH{1'b0}};

    // sticky flags: a period_end in the same cycle as a W1C clear keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_r <= {NUM_CH{1'b0}};
            mask_r   <= {NUM_CH{1'b0}};
            irq_r    <= 1'b0;
        end else begin
            status_r <= (status_r & ~clr_s) | period_end;
            irq_r    <= |(status_r & mask_r);
            if (bus.wr_en && (bus.addr == 8'h03)) begin
                mask_r <= NUM_CH'(bus.wr_data);
            end
        end
    end

    assign irq = irq_r;
`endif

    // register read mux; anything unmapped falls through to zero
    always_comb begin
        rd_s = 8'h00;
        case (bus.addr)
            8'h00: rd_s = ID_VAL;
            8'h01: rd_s = {7'b0000000, global_en_r};
`ifdef PWM_IRQ_EN
            8'h02: rd_s = 8'(status_r);
            8'h03: rd_s = 8'(mask_r);
`endif
            default: begin
                for (int n = 0; n < NUM_CH; n++) begin
                    rd_s = rd_s | ((bus.addr[7:4] == 4'(n + 1)) ? ch_rd_s[n] : 8'h00);
                end
            end
        endcase
    end

    assign bus.rd_data = rd_s;
endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: a phase-based reference model compared every cycle,
// directed waveform checks with hand-computed counts, then randomized register traffic.
module tb_pwm_multi_channel;
    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [NCH-1:0] pwm, period_end;
`ifdef PWM_IRQ_EN
    logic irq;
`endif
    always #5 clk = ~clk;

    pwm_multi_channel_if bus();

    pwm_multi_channel #(.NUM_CH(NCH), .CNT_W(32), .ID_VAL(8'h97)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .pwm        (pwm),
        .period_end (period_end)
`ifdef PWM_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // reference model: position t inside a period of length P (edge) or 2P (centre)
    bit              m_gen;
    bit [2:0]        m_ctrl [NCH];
    logic [31:0]     m_psh [NCH];
    logic [31:0]     m_dsh [NCH];
    longint unsigned m_p [NCH];
    longint unsigned m_d [NCH];
    longint unsigned m_t [NCH];
    bit              m_c [NCH];
    bit [NCH-1:0]    m_pwm, m_stat, m_mask;
    bit              m_irq;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_run(input int n);
        return m_gen && m_ctrl[n][0];
    endfunction

    function automatic longint unsigned m_cnt(input int n);
        if (m_c[n] && (m_t[n] >= m_p[n])) return 2 * m_p[n] - 1 - m_t[n];
        return m_t[n];
    endfunction

    function automatic bit m_pe(input int n);
        longint unsigned len;
        len = m_c[n] ? 2 * m_p[n] : m_p[n];
        return m_run(n) && (m_p[n] != 0) && (m_t[n] == len - 1);
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        int pg, off;
        pg  = int'(a[7:4]);
        off = int'(a[3:0]);
        if (a == 8'h00) return 8'h97;
        if (a == 8'h01) return {7'd0, m_gen};
`ifdef PWM_IRQ_EN
        if (a == 8'h02) return 8'(m_stat);
        if (a == 8'h03) return 8'(m_mask);
`endif
        if (pg < 1 || pg > NCH) return 8'h00;
        if (off == 0) return {5'd0, m_ctrl[pg-1]};
        if (off <= 4) return m_psh[pg-1][8*(off-1) +: 8];
        if (off <= 8) return m_dsh[pg-1][8*(off-5) +: 8];
        return 8'h00;
    endfunction

    task automatic m_reset();
        m_gen = 1'b0; m_pwm = '0; m_stat = '0; m_mask = '0; m_irq = 1'b0;
        for (int n = 0; n < NCH; n++) begin
            m_ctrl[n] = 3'd0; m_psh[n] = 32'h0001_86A0; m_dsh[n] = 32'h0000_C350;
            m_p[n] = 64'h186A0; m_d[n] = 64'hC350; m_t[n] = 0; m_c[n] = 1'b0;
        end
    endtask

    task automatic m_step();
        bit restart;
        bit [NCH-1:0] pe_now, clr;
        int pg, off;
        restart = bus.wr_en && (bus.addr == 8'h01) && bus.wr_data[1];
        clr     = (bus.wr_en && (bus.addr == 8'h02)) ? bus.wr_data[NCH-1:0] : '0;
        m_irq   = |(m_stat & m_mask);
        for (int n = 0; n < NCH; n++) pe_now[n] = m_pe(n);
        for (int n = 0; n < NCH; n++) begin
            m_pwm[n] = (m_run(n) && m_p[n] != 0 && m_cnt(n) < m_d[n]) ? ~m_ctrl[n][1] : m_ctrl[n][1];
            if (restart || !m_run(n) || pe_now[n]) begin
                m_t[n] = 0; m_p[n] = m_psh[n]; m_d[n] = m_dsh[n]; m_c[n] = m_ctrl[n][2];
            end else if (m_p[n] == 0) begin
                m_t[n] = 0;
            end else begin
                m_t[n] = m_t[n] + 1;
            end
        end
        m_stat = (m_stat & ~clr) | pe_now;
        if (bus.wr_en) begin
            pg  = int'(bus.addr[7:4]);
            off = int'(bus.addr[3:0]);
            if (bus.addr == 8'h01) m_gen = bus.wr_data[0];
            if (bus.addr == 8'h03) m_mask = bus.wr_data[NCH-1:0];
            if (pg >= 1 && pg <= NCH) begin
                if (off == 0) m_ctrl[pg-1] = bus.wr_data[2:0];
                else if (off <= 4) m_psh[pg-1][8*(off-1) +: 8] = bus.wr_data;
                else if (off <= 8) m_dsh[pg-1][8*(off-5) +: 8] = bus.wr_data;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else m_step();
    end

    // per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            logic [NCH-1:0] pe_exp;
            for (int n = 0; n < NCH; n++) pe_exp[n] = m_pe(n);
            chk("pwm", 32'(pwm), 32'(m_pwm));
            chk("period_end", 32'(period_end), 32'(pe_exp));
            chk("rd_data", 32'(bus.rd_data), 32'(m_read(bus.addr)));
`ifdef PWM_IRQ_EN
            chk("irq", 32'(irq), 32'(m_irq));
`endif
        end
    end

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #2;
        bus.addr = a; bus.wr_data = d; bus.wr_en = 1'b1;
        @(posedge clk); #2;
        bus.wr_en = 1'b0;
    endtask

    task automatic rd_lit(input string name, input logic [7:0] a, input logic [7:0] exp);
        bus.addr = a; #1;
        chk(name, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic set_ch(input int ch, input logic [31:0] p, input logic [31:0] d, input logic [2:0] c);
        logic [7:0] base;
        base = 8'((ch + 1) * 16);
        for (int k = 0; k < 4; k++) wr(base + 8'(k + 1), p[8*k +: 8]);
        for (int k = 0; k < 4; k++) wr(base + 8'(k + 5), d[8*k +: 8]);
        wr(base, {5'd0, c});
    endtask

    task automatic wait_pe(input int ch);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (period_end[ch]) begin seen = 1'b1; break; end
        end
        chk("period_end_seen", 32'(seen), 32'd1);
    endtask

    task automatic count_hi(input int ch, input int ncyc, output int hi, output int pes);
        hi = 0; pes = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            hi  += int'(pwm[ch]);
            pes += int'(period_end[ch]);
        end
    endtask

    task automatic pe_gap(input int ch, output int gap);
        wait_pe(ch);
        gap = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            gap++;
            if (period_end[ch]) break;
        end
    endtask

    task automatic pick(output logic [7:0] a, output logic [7:0] d);
        int ch, off;
        ch = $urandom_range(1, NCH);
        case ($urandom_range(0, 9))
            0: begin a = 8'h01; d = {6'd0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) != 0)}; end
            1, 2: begin
                a = {4'(ch), 4'h0}; d = {5'd0, 3'($urandom)};
                if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
            end
            3, 4, 5: begin
                off = $urandom_range(1, 4); a = {4'(ch), 4'(off)};
                d = (off == 1) ? 8'($urandom_range(0, 12)) : (($urandom_range(0, 24) == 0) ? 8'($urandom) : 8'h00);
            end
            6, 7: begin
                off = $urandom_range(5, 8); a = {4'(ch), 4'(off)};
                d = (off == 5) ? 8'($urandom_range(0, 14)) : (($urandom_range(0, 24) == 0) ? 8'($urandom) : 8'h00);
            end
            8: begin a = 8'($urandom_range(2, 3)); d = 8'($urandom); end
            default: begin a = 8'($urandom); d = 8'($urandom); end
        endcase
    endtask

    initial begin
        int hi, pes, gap;
        logic [7:0] a, d;
        rst_n = 1'b0; bus.addr = 8'h00; bus.wr_en = 1'b0; bus.wr_data = 8'h00;
        #22 rst_n = 1'b1;
        chk_on = 1'b1;

        // reset state
        chk("reset_pwm", 32'(pwm), 32'd0);
        chk("reset_period_end", 32'(period_end), 32'd0);
        rd_lit("id", 8'h00, 8'h97);
        rd_lit("per0_b0", 8'h11, 8'hA0);
        rd_lit("per0_b1", 8'h12, 8'h86);
        rd_lit("duty0_b0", 8'h15, 8'h50);

        // ch0 edge-aligned P=10 D=3
        wr(8'h01, 8'h01);
        set_ch(0, 32'd10, 32'd3, 3'b001);
        wait_pe(0); @(negedge clk);
        count_hi(0, 10, hi, pes);
        chk("ch0_high_per_period", 32'(hi), 32'd3);
        pe_gap(0, gap);
        chk("ch0_period_end_gap", 32'(gap), 32'd10);

        // ch1 centre-aligned, inverted polarity, P=4 D=1
        set_ch(1, 32'd4, 32'd1, 3'b111);
        wait_pe(1); @(negedge clk);
        count_hi(1, 8, hi, pes);
        chk("ch1_high_per_period", 32'(hi), 32'd6);
        pe_gap(1, gap);
        chk("ch1_period_end_gap", 32'(gap), 32'd8);

        // duty update mid-period applies only from the next period
        wait_pe(0);
        wr(8'h15, 8'd8);
        count_hi(0, 10, hi, pes);
        chk("duty_keep_current", 32'(hi), 32'd3);
        count_hi(0, 10, hi, pes);
        chk("duty_next_period", 32'(hi), 32'd8);

        // boundaries: D=0, D>=P, P=0
        wr(8'h15, 8'd0);
        wait_pe(0); wait_pe(0);
        count_hi(0, 20, hi, pes);
        chk("duty_zero", 32'(hi), 32'd0);
        wr(8'h15, 8'd12);
        wait_pe(0); wait_pe(0);
        count_hi(0, 20, hi, pes);
        chk("duty_ge_period", 32'(hi), 32'd20);
        wr(8'h11, 8'd0);
        wait_pe(0); @(negedge clk);
        count_hi(0, 30, hi, pes);
        chk("period_zero_level", 32'(hi), 32'd0);
        chk("period_zero_no_pe", 32'(pes), 32'd0);
        wr(8'h11, 8'd10);
        wr(8'h01, 8'h03);

`ifdef PWM_IRQ_EN
        wr(8'h11, 8'd5); wr(8'h15, 8'd2); wr(8'h01, 8'h03);
        wr(8'h03, 8'h01); wr(8'h02, 8'hFF);
        wait_pe(0); @(negedge clk); @(negedge clk);
        chk("irq_after_pe", 32'(irq), 32'd1);
        wait_pe(0);
        @(posedge clk); #2; bus.addr = 8'h02; bus.wr_data = 8'h01; bus.wr_en = 1'b1;
        @(posedge clk); #2; bus.wr_en = 1'b0; #1;
        chk("status_w1c", 32'(bus.rd_data[0]), 32'd0);
        wait_pe(0);
        repeat (5) @(posedge clk);
        #2; bus.addr = 8'h02; bus.wr_data = 8'h01; bus.wr_en = 1'b1;
        @(posedge clk); #2; bus.wr_en = 1'b0; #1;
        chk("status_set_beats_clear", 32'(bus.rd_data[0]), 32'd1);
`endif

        // randomized traffic with one asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            if (i == 1500) begin
                bus.wr_en = 1'b0;
                #1 rst_n = 1'b0;
                #1;
                chk("async_reset_pwm", 32'(pwm), 32'd0);
                chk("async_reset_pe", 32'(period_end), 32'd0);
                #3 rst_n = 1'b1;
            end
            pick(a, d);
            bus.addr = a; bus.wr_data = d; bus.wr_en = ($urandom_range(0, 2) == 0);
        end
        @(posedge clk); #2; bus.wr_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
